weight_medium: RTL

Memory-side responder for the CPU's weight interface. It accepts single-cycle read/write enable pulses with an address, moves one W_SIZE-bit weight word to or from narrow internal block-RAM lanes over several beats, and returns a one-cycle finished pulse. It sits between the control unit and the on-chip weight store.

---
 rtl/weight_medium.sv | 93 +++++++++
 1 files changed

// File: rtl/weight_medium.sv
// weight_medium: weight-word responder that moves W_SIZE-bit words to/from WORD_WIDTH-bit BRAM lanes over several beats
module weight_medium #(
  parameter int WEIGHT_LENGTH = 256,
  parameter int W_SIZE = 1024,
  parameter int WORD_WIDTH = 64,
  parameter int BRAM_LATENCY = 2,
  localparam int A_SIZE = $clog2(WEIGHT_LENGTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [A_SIZE-1:0] weight_addr_in,
  input  logic              weight_read_enable_in,
  input  logic              weight_write_enable_in,
  input  logic [W_SIZE-1:0] weight_in,
  output logic [W_SIZE-1:0] weight_out,
  output logic              weight_medium_finished_out,
  output logic              busy_out,
  output logic              protocol_error_out
);
  localparam int BEATS = W_SIZE / WORD_WIDTH;
  localparam int KW = $clog2(BEATS + 1);
  localparam int LA = $clog2(WEIGHT_LENGTH * BEATS);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, nxt;
  logic [KW-1:0] k;
  logic [A_SIZE-1:0] addr_q;
  logic [W_SIZE-1:0] wdata_q, shadow, merged;
  logic bad_q, addr_bad, req, issue, last_ret;
  logic [LA-1:0] lane;
  logic [BRAM_LATENCY-1:0] v_pipe;
  logic [BRAM_LATENCY-1:0][KW-1:0] idx_pipe;
  logic [BRAM_LATENCY-1:0][WORD_WIDTH-1:0] rd_pipe;
  logic [WORD_WIDTH-1:0] mem [WEIGHT_LENGTH*BEATS];
  assign req = weight_read_enable_in || weight_write_enable_in;
  assign addr_bad = {1'b0, weight_addr_in} >= (A_SIZE+1)'(WEIGHT_LENGTH);
  assign lane = LA'(addr_q) * LA'(BEATS) + LA'(k);
  assign issue = state == READ && k != KW'(BEATS);
  assign last_ret = v_pipe[BRAM_LATENCY-1] && idx_pipe[BRAM_LATENCY-1] == KW'(BEATS-1);
  // state register
  always_ff @(posedge clk_in)
    state <= !rst_in ? IDLE : nxt;
  // next-state decode
  always_comb
    nxt = state == IDLE  ? (weight_write_enable_in ? WRITE : weight_read_enable_in ? READ : IDLE) :
          state == WRITE ? (k == KW'(BEATS-1) ? DONE : WRITE) :
          state == READ  ? (last_ret ? DONE : READ) : IDLE;
  // outputs decoded from the state flop only, so no enable reaches them combinationally
  always_comb begin
    busy_out = state != IDLE;
    weight_medium_finished_out = state == DONE;
  end
  // slot the returning beat into its slice; out-of-range reads return zeros
  always_comb begin
    merged = shadow;
    merged[int'(idx_pipe[BRAM_LATENCY-1])*WORD_WIDTH +: WORD_WIDTH] = bad_q ? '0 : rd_pipe[BRAM_LATENCY-1];
  end
  // lane storage with a BRAM_LATENCY-deep read pipeline; never reset
  always_ff @(posedge clk_in) begin
    if (state == WRITE && !bad_q) mem[lane] <= wdata_q[int'(k)*WORD_WIDTH +: WORD_WIDTH];
    rd_pipe[0] <= mem[lane];
    for (int i = 1; i < BRAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  // request latch, beat counter, return tagging, result and sticky error
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      k <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      bad_q <= 1'b0;
      shadow <= '0;
      weight_out <= '0;
      protocol_error_out <= 1'b0;
      v_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      k <= (state == WRITE || issue) ? k + 1'b1 : state == READ ? k : '0;
      if (state == IDLE && req) begin
        addr_q <= weight_addr_in;
        bad_q <= addr_bad;
      end
      if (state == IDLE && weight_write_enable_in) wdata_q <= weight_in;
      protocol_error_out <= protocol_error_out | (state == IDLE ?
        (weight_read_enable_in && weight_write_enable_in) || (req && addr_bad) : req);
      v_pipe[0] <= issue;
      idx_pipe[0] <= k;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      if (v_pipe[BRAM_LATENCY-1]) shadow <= merged;
      if (last_ret) weight_out <= merged;
    end
endmodule
